bsg_downstream_ch_arbiter: RTL
==============================

// Module: bsg_downstream_ch_arbiter
// PURPOSE
//  Round-robin arbiter/scheduler that shares one core-side consumer among NUM_CH
//  bsg_link_ddr_downstream channels. Watches each channel's core_valid_o, returns
//  one core_yumi_i per cycle, and registers the winning word into a 1-entry
//  valid/ready output stage.
//  Sits in the core clock domain, between downstream channel core ports and the core.
// PARAMETERS
//  NUM_CH     2   number of downstream channels arbitrated (>=2)
//  WIDTH      64  core data width per channel (matches channel core_data_o)
//  MAX_BURST  4   max consecutive grants to one channel before forced rotate (>=1)
// PORTS
//  clk               in   1              core clock; all state on posedge
//  rst_n             in   1              synchronous reset, active low
//  ch_valid_i        in   NUM_CH         per-channel core_valid_o
//  ch_data_i         in   NUM_CH*WIDTH   per-channel core_data_o; ch k at [k*WIDTH +: WIDTH]
//  ch_yumi_o         out  NUM_CH         per-channel core_yumi_i; one-hot or zero
//  out_valid_o       out  1              output register holds a word
//  out_data_o        out  WIDTH          registered winning word
//  out_ch_id_o       out  CH_W           source channel of out_data_o; CH_W = max(1, $clog2(NUM_CH))
//  out_ready_i       in   1              consumer accepts word when out_valid_o & out_ready_i
//  stats_clear_i     in   1              clear grant counters (STATS feature only)
//  stats_grant_cnt_o out  NUM_CH*16      per-channel grant counts (STATS feature only)
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): out_valid_o=0, out_data_o=0, out_ch_id_o=0,
//    rr_ptr=0, last_ch=0, burst_cnt=0, state=EMPTY.
//    ch_yumi_o=0 combinationally whenever rst_n==0.
//    Reset mid-transfer discards the held word; no channel is yumi'd.
//  - FSM state EMPTY: out_valid_o=0. A grant in the cycle loads the word -> FULL.
//  - FSM state FULL, out_ready_i=0: word, id and valid held stable; no grant.
//  - FSM state FULL, out_ready_i=1: word retires. A grant in the same cycle
//    reloads the register -> FULL; with no grant -> EMPTY.
//  - can_load = (state==EMPTY) | out_ready_i.
//  - Grant: when can_load, winner = first k with ch_valid_i[k], scanning from
//    rr_ptr upward with wrap NUM_CH-1 -> 0. ch_yumi_o[winner]=1 in the same cycle
//    (yumi depends combinationally on valid, per bsg yumi convention).
//    Data and id appear on out_* the next cycle: latency 1, throughput 1 word/cycle.
//  - Burst rule: winner==last_ch -> burst_cnt+1, otherwise burst_cnt=1.
//    When burst_cnt reaches MAX_BURST: rr_ptr = winner+1 (mod NUM_CH) and
//    burst_cnt=0. Otherwise rr_ptr = winner, so a channel keeps streaming.
//    With MAX_BURST=1 this is pure round robin.
//  - No valid channel: no yumi; rr_ptr and burst_cnt unchanged.
//  - All channels valid: strict rotation by the burst rule; no starvation.
//    Worst-case wait = (NUM_CH-1)*MAX_BURST grants.
//  - Never yumi a channel whose ch_valid_i=0. Never yumi while !can_load.
// CONFIGURATION
//  BSG_DS_ARB_STATS_EN defined:
//    - per-channel 16-bit saturating counters, +1 on each ch_yumi_o[k]
//      (hold at 16'hFFFF).
//    - stats_clear_i=1 zeroes all counters next cycle; a clear overrides an
//      increment in the same cycle.
//    - counters reset to 0.
//  BSG_DS_ARB_STATS_EN undefined: stats_grant_cnt_o tied 0, stats_clear_i ignored,
//    no counter flops.
// STRUCTURE
//  - Package bsg_downstream_arb_pkg:
//      state enum {EMPTY, FULL}; STATS_W=16; function clog2_min1.
//  - Sub-module bsg_downstream_rr_pick: combinational rotating priority picker
//    (valid vector, rr_ptr -> one-hot grant, winner index, any_valid).
//  - Top holds the FSM, output register, rr_ptr/burst logic and optional counters.
// TESTING
//  1 Reset: hold rst_n=0 with all ch_valid_i=1 -> ch_yumi_o=0, out_valid_o=0;
//    release -> first yumi is ch0.
//  2 MAX_BURST=2, both valid, out_ready_i=1 -> yumi order 0,0,1,1,0,0.
//    out_ch_id_o follows one cycle later.
//  3 Backpressure: out_ready_i=0 after one load, data A on ch1 -> out_data_o=A held
//    5 cycles, no yumi. Raise ready -> A retires, next word loads the same cycle.
//  4 Only ch1 valid, NUM_CH=4, rr_ptr=2 -> wrap scan grants ch1.
//    Then ch1 idle -> EMPTY with rr_ptr unchanged.
//  5 Reset mid-FULL -> out_valid_o=0 next cycle; held word never handed over.
//  6 STATS_EN: 70000 grants to ch0 -> counter saturates at 16'hFFFF;
//    stats_clear_i=1 -> 0 next cycle.

Source files
------------

// File: rtl/bsg_downstream_arb_pkg.sv
// Shared types and helpers for the downstream channel arbiter.
package bsg_downstream_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  localparam int STATS_W = 16;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_downstream_rr_pick.sv
// Rotating-priority picker: first valid channel at or after rr_ptr, wrapping.
module bsg_downstream_rr_pick
  import bsg_downstream_arb_pkg::*;
#(
  parameter  int NUM_CH = 2,
  localparam int CH_W   = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   winner,
  output logic              any_valid
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    grant     = '0;
    winner    = '0;
    any_valid = |valid;
    // Scan from the farthest offset back so the nearest valid channel wins.
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      int idx;
      idx = (int'(rr_ptr) + off) % NUM_CH;
      if (valid[idx]) winner = CH_W'(idx);
    end
    if (any_valid) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/bsg_downstream_ch_arbiter.sv
// Round-robin arbiter sharing one core consumer among NUM_CH downstream channels.
// Optional per-channel grant counters are enabled by defining BSG_DS_ARB_STATS_EN.
module bsg_downstream_ch_arbiter
  import bsg_downstream_arb_pkg::*;
#(
  parameter  int NUM_CH    = 2,
  parameter  int WIDTH     = 64,
  parameter  int MAX_BURST = 4,
  localparam int CH_W      = clog2_min1(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         ch_valid_i,
  input  logic [NUM_CH*WIDTH-1:0]   ch_data_i,
  output logic [NUM_CH-1:0]         ch_yumi_o,
  output logic                      out_valid_o,
  output logic [WIDTH-1:0]          out_data_o,
  output logic [CH_W-1:0]           out_ch_id_o,
  input  logic                      out_ready_i,
  input  logic                      stats_clear_i,
  output logic [NUM_CH*STATS_W-1:0] stats_grant_cnt_o
);

  localparam int BC_W = clog2_min1(MAX_BURST + 1);

  arb_state_e        state;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   last_ch;
  logic [BC_W-1:0]   burst_cnt;

  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   winner;
  logic              any_valid;
  logic              can_load;
  logic              load;
  logic [WIDTH-1:0]  sel_data;
  logic [BC_W-1:0]   run_next;
  logic [CH_W-1:0]   ptr_inc;

  bsg_downstream_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .valid     (ch_valid_i),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign can_load    = (state == EMPTY) | out_ready_i;
  assign load        = rst_n & can_load & any_valid;
  assign ch_yumi_o   = load ? grant : '0;
  assign out_valid_o = (state == FULL);

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[k]) sel_data = sel_data | ch_data_i[k*WIDTH +: WIDTH];
    end
  end

  assign run_next = (winner == last_ch) ? burst_cnt + 1'b1 : BC_W'(1);
  assign ptr_inc  = (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state       <= EMPTY;
      out_data_o  <= '0;
      out_ch_id_o <= '0;
      rr_ptr      <= '0;
      last_ch     <= '0;
      burst_cnt   <= '0;
    end else if (load) begin
      state       <= FULL;
      out_data_o  <= sel_data;
      out_ch_id_o <= winner;
      last_ch     <= winner;
      // Hand the pointer on once a channel has used its burst allowance.
      if (run_next == BC_W'(MAX_BURST)) begin
        rr_ptr    <= ptr_inc;
        burst_cnt <= '0;
      end else begin
        rr_ptr    <= winner;
        burst_cnt <= run_next;
      end
    end else if (state == FULL && out_ready_i) begin
      state <= EMPTY;
    end
  end

`ifdef BSG_DS_ARB_STATS_EN
  logic [STATS_W-1:0] grant_cnt [NUM_CH];

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (!rst_n || stats_clear_i) begin
        grant_cnt[k] <= '0;
      end else if (ch_yumi_o[k] && grant_cnt[k] != {STATS_W{1'b1}}) begin
        grant_cnt[k] <= grant_cnt[k] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      stats_grant_cnt_o[k*STATS_W +: STATS_W] = grant_cnt[k];
    end
  end
`else
  logic unused_stats_clear;
  assign unused_stats_clear = stats_clear_i;
  assign stats_grant_cnt_o  = '0;
`endif

endmodule
